// File: rtl/vga_sprite_fetch.sv
// Per-scanline row fetcher for a 16x16 2-bpp sprite: tracks the vertical position,
// fetches the next line's row word during blanking and commits it at end of line.
module vga_sprite_fetch #(
  parameter int unsigned FETCH_H = 640,
  parameter int unsigned LOAD_H  = 799,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic [9:0]  sprite_y,
  input  logic [5:0]  sprite_pixel_size,
  input  logic [3:0]  sprite_base,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] sprite_pixels,
  output logic        row_active,
  output logic        fetch_miss
);

  localparam logic [9:0] FETCH_HC = 10'(FETCH_H);
  localparam logic [9:0] LOAD_HC  = 10'(LOAD_H);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        v_active_q, v_active_d;
  logic [3:0]  row_q, row_d;
  logic [5:0]  size_count_q, size_count_d;
  logic        mem_req_q, mem_req_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] sprite_pixels_q, sprite_pixels_d;
  logic        row_active_q, row_active_d;
  logic        fetch_miss_q, fetch_miss_d;

  logic        at_fetch, at_load;
  logic [9:0]  next_v;

  assign at_fetch = (h_counter == FETCH_HC);
  assign at_load  = (h_counter == LOAD_HC);
  assign next_v   = (v_counter == V_LAST) ? 10'd0 : v_counter + 10'd1;

  always_comb begin
    v_active_d   = v_active_q;
    row_d        = row_q;
    size_count_d = size_count_q;
    // Decision is made for the line that follows, so a sprite_y match restarts it
    if (at_fetch) begin
      if (next_v == sprite_y) begin
        v_active_d   = 1'b1;
        row_d        = 4'd0;
        size_count_d = 6'd0;
      end else if (v_active_q && (size_count_q == sprite_pixel_size)) begin
        size_count_d = 6'd0;
        if (row_q == 4'd15) v_active_d = 1'b0;
        else                row_d      = row_q + 4'd1;
      end else if (v_active_q) begin
        size_count_d = size_count_q + 6'd1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    shadow_d        = shadow_q;
    fetch_miss_d    = 1'b0;
    sprite_pixels_d = sprite_pixels_q;
    row_active_d    = row_active_q;

    if (at_load) begin
      sprite_pixels_d = (state_q == DONE) ? shadow_q : 32'd0;
      row_active_d    = v_active_q && (state_q == DONE);
    end

    case (state_q)
      IDLE: begin
        if (at_fetch) begin
          shadow_d = 32'd0;
          if (v_active_d) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {sprite_base, row_d};
          end
        end
      end
      REQ: begin
        // The deadline wins over an ack arriving on the same cycle
        if (at_load) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          shadow_d     = 32'd0;
          fetch_miss_d = 1'b1;
        end else if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          shadow_d  = mem_data;
        end
      end
      DONE: begin
        if (at_load) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      v_active_q      <= 1'b0;
      row_q           <= 4'd0;
      size_count_q    <= 6'd0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= 8'd0;
      shadow_q        <= 32'd0;
      sprite_pixels_q <= 32'd0;
      row_active_q    <= 1'b0;
      fetch_miss_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      v_active_q      <= v_active_d;
      row_q           <= row_d;
      size_count_q    <= size_count_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      shadow_q        <= shadow_d;
      sprite_pixels_q <= sprite_pixels_d;
      row_active_q    <= row_active_d;
      fetch_miss_q    <= fetch_miss_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign sprite_pixels = sprite_pixels_q;
  assign row_active    = row_active_q;
  assign fetch_miss    = fetch_miss_q;

endmodule
